cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit datapath.
- Drives every datapath control strobe from the latched instruction word and the Z flag.
- Sequences fetch, execute and memory-wait phases.
- Sits beside the datapath in the CPU top level and exposes run/halt status and a retired-instruction count for debug.

Parameters:
- MEM_LATENCY, 1: clock cycles between presenting a read address and read data being valid (1..7).
- COUNT_WIDTH, 16: width of retired_count.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  high = fetch new instructions; low = stop at next instruction boundary
- current_instruction  in  16  latched instruction word from datapath
- Z_out  in  1  zero flag (SR[1]) from datapath
- reg_write, mem_to_reg, fetch_instruction, alu_override_imm8, alu_override_imm4, alu_set_flags, set_pc, pc_from_register, mem_write, set_sp, increase_sp  out  1 each  datapath control strobes
- halted  out  1  high while in HALT
- state_poke  out  3  current state encoding, for debug display
- retired_count  out  COUNT_WIDTH  instructions completed since reset, wraps
- fault  out  1  illegal opcode seen (only with ILLEGAL_TRAP_EN; otherwise tied 0)

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, retired_count=0, halted=0, fault=0, all strobes 0. Strobes are combinational from state+opcode and are 0 in IDLE/HALT.
- States and encodings: IDLE=0, FETCH=1, EXEC=2, MEMWAIT=3, HALT=4.
- IDLE: run=1 -> FETCH, wait counter cleared; else stay.
- FETCH:
  - fetch_instruction=1 for MEM_LATENCY+1 cycles.
  - On the last cycle set_pc=1 with pc_from_register=0 (PC+1) -> EXEC.
- EXEC, one cycle, decoded on opcode = current_instruction[15:12]:
  - 0x0 NOP: no strobes.
  - 0x1 ALU reg-reg: reg_write=1, alu_set_flags=1.
  - 0x2 ALU imm4: reg_write=1, alu_set_flags=1, alu_override_imm4=1.
  - 0x3 LOADI: reg_write=1, alu_override_imm8=1; no flags.
  - 0x4 LOAD: mem_to_reg=1 -> MEMWAIT.
  - 0x5 STORE: mem_write=1.
  - 0x6 JMP: set_pc=1, pc_from_register=1.
  - 0x7 HALT: -> HALT.
  - 0x8 JZ: set_pc=1, pc_from_register=1 only if Z_out=1.
  - 0x9 JNZ: same, only if Z_out=0.
  - 0xA SPINC: set_sp=1, increase_sp=1.
  - 0xB SPDEC: set_sp=1, increase_sp=0.
  - 0xC–0xF: illegal, see optional feature.
- EXEC exit (all opcodes except LOAD and HALT): retired_count+1; run=1 -> FETCH, run=0 -> IDLE.
- MEMWAIT:
  - mem_to_reg=1 held for MEM_LATENCY cycles.
  - On the last cycle reg_write=1 as well; then retire, same run check as EXEC exit.
- HALT: halted=1, all strobes 0, exit only via reset. The HALT instruction is counted as retired on entry.
- Signal rules:
  - mem_to_reg and fetch_instruction are never high in the same cycle.
  - reg_write and mem_write are never high in the same cycle.
- run deasserted mid-instruction: the current instruction completes; the stop takes effect at the boundary.
- retired_count wraps 0xFFFF -> 0x0000 silently.
- Z_out is sampled in EXEC only; it reflects flags from prior instructions.
- Reset mid-instruction: immediate return to IDLE. Partially issued strobes drop asynchronously, and no write strobe may glitch high during reset.

Optional Feature:
- Macro: CPU_SEQUENCER_ILLEGAL_TRAP_EN.
- Defined: opcodes 0xC–0xF in EXEC set fault=1 (sticky until reset) and go to HALT without retiring; halted=1.
- Undefined: 0xC–0xF execute as NOP and retire normally; fault is constant 0.

Test Plan:
- MEM_LATENCY=1, reset released, run=1, instruction 0x1123 -> fetch_instruction high cycles 1–2, set_pc in cycle 2, reg_write+alu_set_flags in cycle 3, retired_count=1 after cycle 3.
- LOAD 0x4120, MEM_LATENCY=2 -> mem_to_reg high 1 EXEC + 2 MEMWAIT cycles, reg_write only in the final cycle, fetch_instruction low throughout.
- JZ 0x8300 with Z_out=1 -> set_pc=1 & pc_from_register=1 in EXEC; repeat with Z_out=0 -> set_pc=0 in EXEC.
- HALT 0x7000 -> state_poke=4, halted=1 and all strobes 0 for 20 cycles; retired_count=1; reset low restores IDLE and halted=0.
- run dropped during the FETCH of a STORE 0x5120 -> mem_write pulses once, then IDLE, no further fetch_instruction; run=1 resumes fetch the next cycle.
- Opcode 0xE000: with CPU_SEQUENCER_ILLEGAL_TRAP_EN -> fault=1, halted=1, retired_count unchanged; without -> retired_count+1, next fetch proceeds.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit datapath: fetch, execute and memory-wait phases.
// Optional illegal-opcode trap enabled by defining CPU_SEQUENCER_ILLEGAL_TRAP_EN.
module cpu_sequencer #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [15:0]            current_instruction,
  input  logic                   Z_out,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   fetch_instruction,
  output logic                   alu_override_imm8,
  output logic                   alu_override_imm4,
  output logic                   alu_set_flags,
  output logic                   set_pc,
  output logic                   pc_from_register,
  output logic                   mem_write,
  output logic                   set_sp,
  output logic                   increase_sp,
  output logic                   halted,
  output logic [2:0]             state_poke,
  output logic [COUNT_WIDTH-1:0] retired_count,
  output logic                   fault
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] MEM_LAST   = CNT_W'(MEM_LATENCY - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             retire;
  logic [3:0]       opcode;
  logic             unused_operand_bits;

  assign opcode              = current_instruction[15:12];
  assign unused_operand_bits = ^current_instruction[11:0];
  assign halted              = (state == HALT);
  assign state_poke          = 3'(state);

`ifdef CPU_SEQUENCER_ILLEGAL_TRAP_EN
  logic trap;
`endif

  // State and counters; reset forces IDLE so every strobe drops immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      retired_count <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (retire) retired_count <= retired_count + COUNT_WIDTH'(1);
    end
  end

`ifdef CPU_SEQUENCER_ILLEGAL_TRAP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    fault <= 1'b0;
    else if (trap) fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif

  // Next state, wait counter and strobe decode.
  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    retire            = 1'b0;
    reg_write         = 1'b0;
    mem_to_reg        = 1'b0;
    fetch_instruction = 1'b0;
    alu_override_imm8 = 1'b0;
    alu_override_imm4 = 1'b0;
    alu_set_flags     = 1'b0;
    set_pc            = 1'b0;
    pc_from_register  = 1'b0;
    mem_write         = 1'b0;
    set_sp            = 1'b0;
    increase_sp       = 1'b0;
`ifdef CPU_SEQUENCER_ILLEGAL_TRAP_EN
    trap              = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (run) begin
          state_next = FETCH;
          cnt_next   = '0;
        end
      end
      FETCH: begin
        fetch_instruction = 1'b1;
        if (cnt == FETCH_LAST) begin
          set_pc     = 1'b1;
          state_next = EXEC;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      EXEC: begin
        retire     = 1'b1;
        cnt_next   = '0;
        state_next = run ? FETCH : IDLE;
        case (opcode)
          4'h0: ;
          4'h1: begin reg_write = 1'b1; alu_set_flags = 1'b1; end
          4'h2: begin reg_write = 1'b1; alu_set_flags = 1'b1; alu_override_imm4 = 1'b1; end
          4'h3: begin reg_write = 1'b1; alu_override_imm8 = 1'b1; end
          4'h4: begin mem_to_reg = 1'b1; retire = 1'b0; state_next = MEMWAIT; end
          4'h5: mem_write = 1'b1;
          4'h6: begin set_pc = 1'b1; pc_from_register = 1'b1; end
          4'h7: state_next = HALT;
          4'h8: begin set_pc = Z_out; pc_from_register = Z_out; end
          4'h9: begin set_pc = ~Z_out; pc_from_register = ~Z_out; end
          4'hA: begin set_sp = 1'b1; increase_sp = 1'b1; end
          4'hB: set_sp = 1'b1;
`ifdef CPU_SEQUENCER_ILLEGAL_TRAP_EN
          default: begin retire = 1'b0; trap = 1'b1; state_next = HALT; end
`else
          default: ;
`endif
        endcase
      end
      MEMWAIT: begin
        mem_to_reg = 1'b1;
        if (cnt == MEM_LAST) begin
          reg_write  = 1'b1;
          retire     = 1'b1;
          cnt_next   = '0;
          state_next = run ? FETCH : IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HALT: ;
      default: state_next = IDLE;
    endcase
  end

endmodule
